// File: rtl/vga_sync_rx.sv
// VGA receive front end: measures incoming sync timing, locks against the expected
// raster, then recovers active-area pixel coordinates and gated video.
module vga_sync_rx #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [VIDEO_WIDTH-1:0] i_red_video,
  input  logic [VIDEO_WIDTH-1:0] i_green_video,
  input  logic [VIDEO_WIDTH-1:0] i_blue_video,
  output logic [10:0]            o_h_total,
  output logic [10:0]            o_h_sync_width,
  output logic [10:0]            o_v_total,
  output logic                   o_locked,
  output logic                   o_active,
  output logic [9:0]             o_x,
  output logic [9:0]             o_y,
  output logic                   o_frame_start,
  output logic [VIDEO_WIDTH-1:0] o_red_video,
  output logic [VIDEO_WIDTH-1:0] o_green_video,
  output logic [VIDEO_WIDTH-1:0] o_blue_video
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam int          MW      = $clog2(LOCK_FRAMES + 1);
  localparam logic        SP      = (SYNC_POL != 0);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [10:0] H_TOT   = 11'(TOTAL_COLS);
  localparam logic [10:0] V_TOT   = 11'(TOTAL_ROWS);
  localparam logic [10:0] H_BEG   = 11'(H_ACT_START);
  localparam logic [10:0] H_END   = 11'(H_ACT_START + ACTIVE_COLS);
  localparam logic [10:0] V_BEG   = 11'(V_ACT_START);
  localparam logic [10:0] V_END   = 11'(V_ACT_START + ACTIVE_ROWS);
  localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_FRAMES);

  logic                   hs_r, hs_d, vs_r, vs_d;
  logic [VIDEO_WIDTH-1:0] red_r, green_r, blue_r;
  logic                   hs_lead, hs_trail, vs_lead;
  logic [10:0]            h_cnt, h_inc, h_cnt_nx, h_total_nx;
  logic [10:0]            v_cnt, v_inc, v_cnt_nx;
  logic [10:0]            hx, vy;
  logic                   ovf, ovf_nx, ovf_seen, frame_good, act_nx;
  state_t                 state, state_nx;
  logic [MW-1:0]          match_cnt, match_nx, match_inc;

  assign hs_lead  = (hs_r == SP) && (hs_d != SP);
  assign hs_trail = (hs_r != SP) && (hs_d == SP);
  assign vs_lead  = (vs_r == SP) && (vs_d != SP);

  // Counter next-state. v_inc already includes this cycle's hsync edge, so a
  // vsync edge counts the same number of lines whether or not it lands on an
  // hsync edge (the coincident reset then discards that increment).
  always_comb begin
    h_inc      = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
    h_cnt_nx   = hs_lead ? 11'd0 : h_inc;
    ovf_nx     = !hs_lead && (ovf || (h_inc == CNT_MAX));
    h_total_nx = hs_lead ? h_cnt + 11'd1 : o_h_total;
    v_inc      = (hs_lead && (v_cnt != CNT_MAX)) ? v_cnt + 11'd1 : v_cnt;
    v_cnt_nx   = vs_lead ? 11'd0 : v_inc;
    frame_good = (h_total_nx == H_TOT) && (v_inc == V_TOT) && !ovf_seen && !ovf_nx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    match_nx  = match_cnt;
    match_inc = match_cnt + MW'(1);
    case (state)
      SEARCH: if (vs_lead) begin
        state_nx = VERIFY;
        match_nx = '0;
      end
      VERIFY: if (vs_lead) begin
        if (!frame_good)                   match_nx = '0;
        else if (match_inc == MATCH_LOCK) begin
          state_nx = LOCKED;
          match_nx = '0;
        end else                           match_nx = match_inc;
      end
      LOCKED: if (vs_lead && !frame_good) begin
        state_nx = VERIFY;
        match_nx = '0;
      end
      default: begin
        state_nx = SEARCH;
        match_nx = '0;
      end
    endcase
    if (ovf_nx) begin
      state_nx = SEARCH;
      match_nx = '0;
    end
  end

  // Pixel stage works on the counter values being loaded this cycle, so the
  // outputs line up with the h_cnt/v_cnt registers they update alongside.
  always_comb begin
    hx     = h_cnt_nx - H_BEG;
    vy     = v_cnt_nx - V_BEG;
    act_nx = (state_nx == LOCKED) &&
             (h_cnt_nx >= H_BEG) && (h_cnt_nx < H_END) &&
             (v_cnt_nx >= V_BEG) && (v_cnt_nx < V_END);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs_r <= ~SP; hs_d <= ~SP; vs_r <= ~SP; vs_d <= ~SP;
      red_r <= '0; green_r <= '0; blue_r <= '0;
      h_cnt <= '0; v_cnt <= '0; ovf <= 1'b0; ovf_seen <= 1'b0;
      o_h_total <= '0; o_h_sync_width <= '0; o_v_total <= '0;
      o_locked <= 1'b0; o_active <= 1'b0; o_x <= '0; o_y <= '0;
      o_frame_start <= 1'b0;
      o_red_video <= '0; o_green_video <= '0; o_blue_video <= '0;
    end else begin
      hs_r    <= i_hsync;  hs_d <= hs_r;
      vs_r    <= i_vsync;  vs_d <= vs_r;
      red_r   <= i_red_video;
      green_r <= i_green_video;
      blue_r  <= i_blue_video;

      h_cnt     <= h_cnt_nx;
      v_cnt     <= v_cnt_nx;
      ovf       <= ovf_nx;
      ovf_seen  <= vs_lead ? 1'b0 : (ovf_seen | ovf_nx);
      o_h_total <= h_total_nx;
      if (hs_trail) o_h_sync_width <= h_cnt + 11'd1;
      if (vs_lead)  o_v_total      <= v_inc;

      o_locked      <= (state_nx == LOCKED);
      o_active      <= act_nx;
      o_x           <= act_nx ? hx[9:0] : 10'd0;
      o_y           <= act_nx ? vy[9:0] : 10'd0;
      o_frame_start <= act_nx && (hx == 11'd0) && (vy == 11'd0);
      o_red_video   <= act_nx ? red_r   : '0;
      o_green_video <= act_nx ? green_r : '0;
      o_blue_video  <= act_nx ? blue_r  : '0;
    end
  end
endmodule
